// File: rtl/mic4_pulse_seq.sv
// Pulse sequencer: optional GRST pulse, then repeated A -> S -> D pulse trains separated by programmable gaps.
// Optional feature macro MIC4_SEQ_EXT_TRIG_EN adds trig_in and a W_TRIG state that gates every A pulse.
module mic4_pulse_seq #(
  parameter int DLY_WIDTH = 16,
  parameter int REP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 grst_en,
  input  logic [DLY_WIDTH-1:0] dly_ga,
  input  logic [DLY_WIDTH-1:0] dly_as,
  input  logic [DLY_WIDTH-1:0] dly_sd,
  input  logic [DLY_WIDTH-1:0] dly_per,
  input  logic [REP_WIDTH-1:0] n_rep,
`ifdef MIC4_SEQ_EXT_TRIG_EN
  input  logic                 trig_in,
`endif
  output logic                 pulse_grst,
  output logic                 pulse_a,
  output logic                 pulse_s,
  output logic                 pulse_d,
  output logic                 busy,
  output logic                 done,
  output logic [REP_WIDTH-1:0] rep_cnt,
  output logic [3:0]           state_dbg
);

  // Handshake: start and abort are single-cycle strobes sampled on clk_in; start is
  // accepted only in IDLE with abort low, and busy rises the cycle after acceptance.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    GRST  = 4'd1,
    W_GA  = 4'd2,
    APLS  = 4'd3,
    W_AS  = 4'd4,
    SPLS  = 4'd5,
    W_SD  = 4'd6,
    DPLS  = 4'd7,
    W_PER = 4'd8,
    FIN   = 4'd9
`ifdef MIC4_SEQ_EXT_TRIG_EN
    , W_TRIG = 4'd10
`endif
  } state_t;

  // Every path toward an A pulse goes through this entry point.
`ifdef MIC4_SEQ_EXT_TRIG_EN
  localparam state_t A_ENTRY = W_TRIG;
  localparam logic   A_PULSE = 1'b0;
`else
  localparam state_t A_ENTRY = APLS;
  localparam logic   A_PULSE = 1'b1;
`endif

  localparam logic [DLY_WIDTH-1:0] DLY_ONE = 1;
  localparam logic [REP_WIDTH-1:0] REP_ONE = 1;

  state_t               state;
  logic [DLY_WIDTH-1:0] cnt;
  logic [DLY_WIDTH-1:0] sh_ga;
  logic [DLY_WIDTH-1:0] sh_as;
  logic [DLY_WIDTH-1:0] sh_sd;
  logic [DLY_WIDTH-1:0] sh_per;
  logic [REP_WIDTH-1:0] sh_rep;
  logic                 more_reps;
`ifdef MIC4_SEQ_EXT_TRIG_EN
  logic                 trig_q;
`endif

  assign state_dbg = state;
  // rep_cnt already includes the D pulse of the current iteration when this is used.
  assign more_reps = (sh_rep == '0) || (rep_cnt < sh_rep);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sh_ga      <= '0;
      sh_as      <= '0;
      sh_sd      <= '0;
      sh_per     <= '0;
      sh_rep     <= '0;
      rep_cnt    <= '0;
      pulse_grst <= 1'b0;
      pulse_a    <= 1'b0;
      pulse_s    <= 1'b0;
      pulse_d    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MIC4_SEQ_EXT_TRIG_EN
      trig_q     <= 1'b0;
`endif
    end else begin
      pulse_grst <= 1'b0;
      pulse_a    <= 1'b0;
      pulse_s    <= 1'b0;
      pulse_d    <= 1'b0;
      done       <= 1'b0;
`ifdef MIC4_SEQ_EXT_TRIG_EN
      trig_q     <= trig_in;
`endif
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // grst_en is consumed right here, so later changes cannot affect the run.
            if (start && !abort) begin
              sh_ga   <= dly_ga;
              sh_as   <= dly_as;
              sh_sd   <= dly_sd;
              sh_per  <= dly_per;
              sh_rep  <= n_rep;
              rep_cnt <= '0;
              busy    <= 1'b1;
              if (grst_en) begin
                state      <= GRST;
                pulse_grst <= 1'b1;
              end else begin
                state   <= A_ENTRY;
                pulse_a <= A_PULSE;
              end
            end
          end
          GRST: begin
            if (sh_ga == '0) begin
              state   <= A_ENTRY;
              pulse_a <= A_PULSE;
            end else begin
              state <= W_GA;
              cnt   <= sh_ga - DLY_ONE;
            end
          end
          W_GA: begin
            if (cnt == '0) begin
              state   <= A_ENTRY;
              pulse_a <= A_PULSE;
            end else begin
              cnt <= cnt - DLY_ONE;
            end
          end
`ifdef MIC4_SEQ_EXT_TRIG_EN
          W_TRIG: begin
            if (trig_in && !trig_q) begin
              state   <= APLS;
              pulse_a <= 1'b1;
            end
          end
`endif
          APLS: begin
            if (sh_as == '0) begin
              state   <= SPLS;
              pulse_s <= 1'b1;
            end else begin
              state <= W_AS;
              cnt   <= sh_as - DLY_ONE;
            end
          end
          W_AS: begin
            if (cnt == '0) begin
              state   <= SPLS;
              pulse_s <= 1'b1;
            end else begin
              cnt <= cnt - DLY_ONE;
            end
          end
          SPLS: begin
            if (sh_sd == '0) begin
              state   <= DPLS;
              pulse_d <= 1'b1;
              rep_cnt <= rep_cnt + REP_ONE;
            end else begin
              state <= W_SD;
              cnt   <= sh_sd - DLY_ONE;
            end
          end
          W_SD: begin
            if (cnt == '0) begin
              state   <= DPLS;
              pulse_d <= 1'b1;
              rep_cnt <= rep_cnt + REP_ONE;
            end else begin
              cnt <= cnt - DLY_ONE;
            end
          end
          DPLS: begin
            // The final iteration skips the period gap so done follows pulse_d directly.
            if (!more_reps) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (sh_per == '0) begin
              state   <= A_ENTRY;
              pulse_a <= A_PULSE;
            end else begin
              state <= W_PER;
              cnt   <= sh_per - DLY_ONE;
            end
          end
          W_PER: begin
            if (cnt != '0) begin
              cnt <= cnt - DLY_ONE;
            end else if (more_reps) begin
              state   <= A_ENTRY;
              pulse_a <= A_PULSE;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
          FIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mic4_pulse_seq.sv
// Bench for mic4_pulse_seq: a timeline model pushes expected pulse events, a negedge monitor pops and compares them.
module tb_mic4_pulse_seq;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int EW = 21;
  localparam logic [4:0] EV_G = 5'b10000;
  localparam logic [4:0] EV_A = 5'b01000;
  localparam logic [4:0] EV_S = 5'b00100;
  localparam logic [4:0] EV_D = 5'b00010;
  localparam logic [4:0] EV_F = 5'b00001;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          grst_en = 1'b0;
  logic [DW-1:0] dly_ga = '0;
  logic [DW-1:0] dly_as = '0;
  logic [DW-1:0] dly_sd = '0;
  logic [DW-1:0] dly_per = '0;
  logic [RW-1:0] n_rep = '0;
`ifdef MIC4_SEQ_EXT_TRIG_EN
  logic          trig_in = 1'b0;
`endif
  logic          pulse_grst, pulse_a, pulse_s, pulse_d, busy, done;
  logic [RW-1:0] rep_cnt;
  logic [3:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_ev;
  logic [4:0]    ev;

  mic4_pulse_seq #(.DLY_WIDTH(DW), .REP_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .grst_en(grst_en),
    .dly_ga(dly_ga), .dly_as(dly_as), .dly_sd(dly_sd), .dly_per(dly_per), .n_rep(n_rep),
`ifdef MIC4_SEQ_EXT_TRIG_EN
    .trig_in(trig_in),
`endif
    .pulse_grst(pulse_grst), .pulse_a(pulse_a), .pulse_s(pulse_s), .pulse_d(pulse_d),
    .busy(busy), .done(done), .rep_cnt(rep_cnt), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: every asserted pulse/done must match the head of the expected queue
  always @(negedge clk_in) begin
    ev = {pulse_grst, pulse_a, pulse_s, pulse_d, done};
    if (ev != 5'b0) begin
      got_ev = {ev, 16'(cyc - t0)};
      if (exp_q.size() == 0) check("unexpected_event", 32'(got_ev), 32'h0);
      else check("event", 32'(got_ev), 32'(exp_q.pop_front()));
    end
  end

  task automatic push(input logic [4:0] kind, input int t);
    exp_q.push_back({kind, 16'(t)});
  endtask

  // timeline model; t_last returns the rel cycle of the final event pushed
  task automatic push_run(input bit g, input int ga, input int as_, input int sd, input int per,
                          input int nrep, input int max_d, output int t_last);
    int t;
    int k;
    t = 1;
    k = 0;
    if (g) begin
      push(EV_G, t);
      t += ga + 1;
    end
    while (1) begin
      push(EV_A, t); t += as_ + 1;
      push(EV_S, t); t += sd + 1;
      push(EV_D, t); k++;
      t_last = t;
      if (nrep != 0 && k >= nrep) begin
        push(EV_F, t + 1);
        t_last = t + 1;
        break;
      end
      if (k >= max_d) break;
      t += per + 1;
    end
  endtask

  // drives a start, then scrambles the config inputs to prove they were shadowed
  task automatic do_start(input bit g, input int ga, input int as_, input int sd, input int per,
                          input int nrep);
    @(negedge clk_in);
    grst_en = g; dly_ga = DW'(ga); dly_as = DW'(as_); dly_sd = DW'(sd);
    dly_per = DW'(per); n_rep = RW'(nrep); start = 1'b1; t0 = cyc;
    @(negedge clk_in);
    start = 1'b0;
    grst_en = 1'($urandom_range(0, 1));
    dly_ga = DW'($urandom_range(0, 20)); dly_as = DW'($urandom_range(0, 20));
    dly_sd = DW'($urandom_range(0, 20)); dly_per = DW'($urandom_range(0, 20));
    n_rep = RW'($urandom_range(0, 9));
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && exp_q.size() == 0) break;
      @(negedge clk_in);
    end
    check({tag, "_idle"}, 32'(busy) + 32'(exp_q.size()), 32'h0);
  endtask

  task automatic run_seq(input string tag, input bit g, input int ga, input int as_, input int sd,
                         input int per, input int nrep);
    int t_last;
    push_run(g, ga, as_, sd, per, nrep, 100000, t_last);
    do_start(g, ga, as_, sd, per, nrep);
    check({tag, "_busy_rise"}, 32'(busy), 32'h1);
    wait_idle(tag, 3000);
    check({tag, "_busy_fall"}, 32'(cyc - t0), 32'(t_last + 1));
    check({tag, "_rep_cnt"}, 32'(rep_cnt), 32'(nrep));
  endtask

  initial begin
    int t_last;
    repeat (3) @(negedge clk_in);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pulses", 32'({pulse_grst, pulse_a, pulse_s, pulse_d, done}), 32'h0);
    check("rst_rep_cnt", 32'(rep_cnt), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

`ifdef MIC4_SEQ_EXT_TRIG_EN
    // trigger-gated run: A pulses only after trig_in edges at rel 20 and 60
    push(EV_A, 21); push(EV_S, 24); push(EV_D, 27);
    push(EV_A, 61); push(EV_S, 64); push(EV_D, 67); push(EV_F, 68);
    do_start(1'b0, 0, 2, 2, 2, 2);
    for (int i = 0; i < 200; i++) begin
      trig_in = ((cyc - t0) == 20 || (cyc - t0) == 60);
      if (!busy && exp_q.size() == 0) break;
      @(negedge clk_in);
    end
    trig_in = 1'b0;
    check("trig_pending", 32'(exp_q.size()) + 32'(busy), 32'h0);
    check("trig_rep_cnt", 32'(rep_cnt), 32'h2);
`else
    run_seq("basic", 1'b1, 3, 5, 2, 0, 1);
    run_seq("b2b", 1'b0, 0, 0, 0, 0, 3);
    for (int r = 0; r < 4; r++)
      run_seq("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 3));

    // endless mode, abort right after the 4th D pulse
    push_run(1'b1, 2, 1, 1, 10, 0, 4, t_last);
    do_start(1'b1, 2, 1, 1, 10, 0);
    for (int i = 0; i < 500; i++) begin
      if (pulse_d && rep_cnt == RW'(4)) break;
      @(negedge clk_in);
    end
    check("abort_reached_d4", 32'(rep_cnt), 32'h4);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_state", 32'(state_dbg), 32'h0);
    repeat (30) @(negedge clk_in);
    check("abort_rep_cnt", 32'(rep_cnt), 32'h4);
    check("abort_pending", 32'(exp_q.size()), 32'h0);

    // start and abort together in IDLE: start must be ignored
    @(negedge clk_in);
    start = 1'b1; abort = 1'b1; grst_en = 1'b1;
    @(negedge clk_in);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'h0);
    repeat (10) @(negedge clk_in);
    check("start_abort_idle", 32'(busy) + 32'(state_dbg), 32'h0);

    // a second start while busy must not disturb the running sequence
    push_run(1'b1, 2, 3, 1, 2, 2, 100000, t_last);
    do_start(1'b1, 2, 3, 1, 2, 2);
    repeat (2) @(negedge clk_in);
    start = 1'b1; grst_en = 1'b0; dly_as = '0; dly_sd = '0; n_rep = RW'(5);
    @(negedge clk_in);
    start = 1'b0;
    wait_idle("restart", 500);
    check("restart_busy_fall", 32'(cyc - t0), 32'(t_last + 1));
    check("restart_rep_cnt", 32'(rep_cnt), 32'h2);

    // reset during W_AS
    push(EV_A, 1);
    do_start(1'b0, 0, 8, 1, 0, 1);
    repeat (2) @(negedge clk_in);
    check("was_state", 32'(state_dbg), 32'h4);
    #2 rst_n = 1'b0;
    #1 check("was_rst_busy", 32'(busy) + 32'(state_dbg), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // reset while pulse_a is high: it must drop before the next clock edge
    push(EV_A, 1);
    do_start(1'b0, 0, 3, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_pulse", 32'(pulse_a), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_in);
    check("rst_no_pulses", 32'(exp_q.size()) + 32'(busy), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mic4_pulse_seq.md
MIC4_PULSE_SEQ -- requirements
Module: mic4_pulse_seq

Interface
REQ-001 SHALL have parameter DLY_WIDTH, default 16, width of every delay/period field.
REQ-002 SHALL have parameter REP_WIDTH, default 16, width of repetition count.
REQ-003 SHALL have port clk_in  input  1  control clock (100MHz), sole clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to launch a sequence.
REQ-006 SHALL have port abort  input  1  single-cycle request to stop immediately.
REQ-007 SHALL have port grst_en  input  1  issue pulse_grst before the first iteration.
REQ-008 SHALL have ports dly_ga, dly_as, dly_sd, dly_per  input  DLY_WIDTH  gaps GRST->A, A->S, S->D, D->next A.
REQ-009 SHALL have port n_rep  input  REP_WIDTH  iterations; 0 = run until abort.
REQ-010 SHALL have ports pulse_grst, pulse_a, pulse_s, pulse_d  output  1  single-cycle requests to the downstream pulse stretchers.
REQ-011 SHALL have port busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-012 SHALL have port done  output  1  single-cycle flag on normal completion.
REQ-013 SHALL have port rep_cnt  output  REP_WIDTH  completed D pulses in current/last run.

Function
REQ-014 SHALL implement states IDLE, GRST, W_GA, APLS, W_AS, SPLS, W_SD, DPLS, W_PER, FIN.
REQ-015 SHALL accept start only in IDLE; start while busy ignored.
REQ-016 SHALL latch grst_en, all dly_* and n_rep into shadow registers on accepted start; later input changes have no effect until next start.
REQ-017 SHALL go IDLE->GRST if grst_en else IDLE->APLS on accepted start.
REQ-018 SHALL register all pulse outputs; each pulse high exactly one cycle, in the cycle after entering its pulse state's predecessor transition (first pulse 1 cycle after start).
REQ-019 SHALL space consecutive pulse rising edges by exactly dly_x+1 cycles; dly_x=0 gives back-to-back pulses.
REQ-020 SHALL clear rep_cnt on accepted start and increment it in the cycle pulse_d is asserted; rep_cnt wraps modulo 2^REP_WIDTH in n_rep=0 mode.
REQ-021 SHALL, after W_PER, return to APLS if n_rep=0 or rep_cnt<n_rep, else go to FIN; pulse_grst never repeats within a run.
REQ-022 SHALL skip W_PER when the last iteration completes: pulse_d of final iteration followed by done exactly one cycle later, then IDLE.
REQ-023 SHALL, on abort in any non-IDLE state, enter IDLE next cycle, emit no further pulse, not assert done, keep rep_cnt.
REQ-024 SHALL give abort priority over start when both asserted in the same cycle in IDLE (start ignored).
REQ-025 SHALL never assert two pulse outputs in the same cycle.
REQ-026 SHALL use down-counters loaded with dly_x on entering each wait state; terminal count at zero.

Reset
REQ-027 SHALL, while rst_n low, force state IDLE, all pulse outputs, busy, done to 0, rep_cnt to 0, shadow registers to 0.
REQ-028 SHALL, on reset assertion mid-sequence, drop any pulse in flight immediately; first pulse after release only on a new start.

Configuration
REQ-029 SHALL, with macro MIC4_SEQ_EXT_TRIG_EN defined, add input trig_in (1 bit, synchronous to clk_in) and state W_TRIG before every APLS, leaving W_TRIG one cycle after a sampled 0->1 edge of trig_in; abort also exits W_TRIG.
REQ-030 SHALL, without MIC4_SEQ_EXT_TRIG_EN, omit trig_in and W_TRIG entirely, timing per REQ-019.

Verification
REQ-031 grst_en=1, dly_ga=3, dly_as=5, dly_sd=2, n_rep=1, start at cycle 0 -> grst@1, a@5, s@11, d@14, done@15, rep_cnt=1, busy low @16.
REQ-032 grst_en=0, all dly=0, n_rep=3 -> a,s,d,(per) back-to-back cycles, three d pulses, done once, rep_cnt=3.
REQ-033 n_rep=0, dly_per=10, abort after 4th pulse_d -> IDLE next cycle, no done, rep_cnt=4, no further pulses.
REQ-034 start+abort same cycle in IDLE -> busy stays 0, no pulses; start during busy -> ignored, sequence timing unchanged.
REQ-035 rst_n low during W_AS -> outputs 0 asynchronously; after release no pulses until new start.
REQ-036 MIC4_SEQ_EXT_TRIG_EN defined, n_rep=2, trig_in rising at cycles 20 and 60 -> pulse_a at 21 and 61 only.
